// File: rtl/adder_pkg.sv
// Shared definitions for the segmented pipelined adder.
package adder_pkg;

  localparam logic MODE_ADD = 1'b0;
  localparam logic MODE_SUB = 1'b1;

  // Number of ripple segments, which is also the pipeline depth.
  function automatic int calc_nseg(input int width, input int seg_w);
    return width / seg_w;
  endfunction

  // Operand width must split into whole segments.
  function automatic bit seg_fit_ok(input int width, input int seg_w);
    return (seg_w > 0) && (width >= seg_w) && ((width % seg_w) == 0);
  endfunction

endpackage

// File: rtl/full_adder.sv
// Single-bit full adder cell.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);

  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (ci & (a ^ b));

endmodule

// File: rtl/ripple_segment.sv
// Combinational SEG_W-bit ripple of full_adder cells.
module ripple_segment #(
  parameter int SEG_W = 4
) (
  input  logic [SEG_W-1:0] a,
  input  logic [SEG_W-1:0] b,
  input  logic             ci,
  output logic [SEG_W-1:0] s,
  output logic             co
);

  // Each cell owns its carry net so the chain is a plain sequence of
  // separate signals rather than a self-referencing vector.
  for (genvar i = 0; i < SEG_W; i++) begin : g_bit
    logic w_ci;
    logic w_co;
    if (i == 0) begin : g_lsb
      assign w_ci = ci;
    end else begin : g_up
      assign w_ci = g_bit[i-1].w_co;
    end
    full_adder u_fa (
      .a (a[i]),
      .b (b[i]),
      .ci(w_ci),
      .s (s[i]),
      .co(w_co)
    );
  end

  assign co = g_bit[SEG_W-1].w_co;

endmodule

// File: rtl/pipelined_carry_adder.sv
// WIDTH-bit add/subtract split into SEG_W-bit ripple segments, one pipeline
// stage per segment, with the inter-segment carry registered. A single
// global enable stalls the whole pipe when the output is held.
// Note for integration: in_ready is a combinational function of out_ready.
module pipelined_carry_adder
  import adder_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int SEG_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
  input  logic             Sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] Sum,
  output logic             Cout,
  output logic             Ovf
);

  localparam int NSEG = calc_nseg(WIDTH, SEG_W);

  if (!seg_fit_ok(WIDTH, SEG_W)) begin : g_bad_split
    $error("pipelined_carry_adder: WIDTH must be a nonzero multiple of SEG_W");
  end

  logic             w_en;
  logic [WIDTH-1:0] w_b_eff;
  logic             w_c0;
  logic             w_ovf_nxt;
  logic             r_ovf;

  assign w_en     = !out_valid || out_ready;
  assign in_ready = w_en;

  // Subtraction is A + ~B + 1; Cin only matters in add mode.
  assign w_b_eff = (Sub == MODE_SUB) ? ~B : B;
  assign w_c0    = (Sub == MODE_SUB) ? 1'b1 : Cin;

  // Stage k consumes the low segment of the operands still in flight,
  // appends its sum bits above the finished lower bits, and forwards the
  // remaining upper operand bits to the next stage.
  for (genvar k = 0; k < NSEG; k++) begin : g_stg
    localparam int IN_W  = WIDTH - k * SEG_W;
    localparam int REM_W = IN_W - SEG_W;
    localparam int SUM_W = (k + 1) * SEG_W;

    logic [IN_W-1:0]  w_a_cur;
    logic [IN_W-1:0]  w_b_cur;
    logic             w_c_cur;
    logic             w_v_cur;
    logic [SEG_W-1:0] w_seg_s;
    logic             w_seg_co;
    logic [SUM_W-1:0] w_sum_cur;

    logic             r_vld;
    logic [SUM_W-1:0] r_sum;
    logic             r_c;

    if (k == 0) begin : g_first
      assign w_a_cur   = A;
      assign w_b_cur   = w_b_eff;
      assign w_c_cur   = w_c0;
      assign w_v_cur   = in_valid;
      assign w_sum_cur = w_seg_s;
    end else begin : g_next
      assign w_a_cur   = g_stg[k-1].g_op.r_a;
      assign w_b_cur   = g_stg[k-1].g_op.r_b;
      assign w_c_cur   = g_stg[k-1].r_c;
      assign w_v_cur   = g_stg[k-1].r_vld;
      assign w_sum_cur = {w_seg_s, g_stg[k-1].r_sum};
    end

    ripple_segment #(.SEG_W(SEG_W)) u_seg (
      .a (w_a_cur[SEG_W-1:0]),
      .b (w_b_cur[SEG_W-1:0]),
      .ci(w_c_cur),
      .s (w_seg_s),
      .co(w_seg_co)
    );

    // Valid bit, partial sum and carry of this stage advance together.
    always_ff @(posedge clk) begin
      if (rst) begin
        r_vld <= 1'b0;
        r_sum <= '0;
        r_c   <= 1'b0;
      end else if (w_en) begin
        r_vld <= w_v_cur;
        r_sum <= w_sum_cur;
        r_c   <= w_seg_co;
      end
    end

    if (REM_W > 0) begin : g_op
      logic [REM_W-1:0] r_a;
      logic [REM_W-1:0] r_b;

      // Carry the not-yet-added operand bits forward.
      always_ff @(posedge clk) begin
        if (rst) begin
          r_a <= '0;
          r_b <= '0;
        end else if (w_en) begin
          r_a <= w_a_cur[IN_W-1:SEG_W];
          r_b <= w_b_cur[IN_W-1:SEG_W];
        end
      end
    end
  end

  // Signed overflow: operand signs agree but the result sign differs.
  assign w_ovf_nxt =
    (g_stg[NSEG-1].w_a_cur[SEG_W-1] == g_stg[NSEG-1].w_b_cur[SEG_W-1]) &&
    (g_stg[NSEG-1].w_seg_s[SEG_W-1] != g_stg[NSEG-1].w_a_cur[SEG_W-1]);

  // Overflow flag registered alongside the final stage.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ovf <= 1'b0;
    end else if (w_en) begin
      r_ovf <= w_ovf_nxt;
    end
  end

  assign out_valid = g_stg[NSEG-1].r_vld;
  assign Sum       = g_stg[NSEG-1].r_sum;
  assign Cout      = g_stg[NSEG-1].r_c;
  assign Ovf       = r_ovf;

endmodule

// File: tb/tb_pipelined_carry_adder.sv
// Scoreboard bench for pipelined_carry_adder (16-bit, 4-bit segments).
module tb_pipelined_carry_adder;
  import adder_pkg::*;

  localparam int WIDTH = 16;
  localparam int SEG_W = 4;
  localparam int NSEG  = WIDTH / SEG_W;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             Cin;
  logic             Sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] Sum;
  logic             Cout;
  logic             Ovf;

  typedef struct {
    logic [15:0] sum;
    logic        cout;
    logic        ovf;
    int          acc;
  } exp_t;

  exp_t q[$];
  exp_t exp_next;
  int   n_cmp = 0;
  int   n_fail = 0;
  int   cyc = 0;

  always #5 clk = ~clk;

  pipelined_carry_adder #(.WIDTH(WIDTH), .SEG_W(SEG_W)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .A        (A),
    .B        (B),
    .Cin      (Cin),
    .Sub      (Sub),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .Sum      (Sum),
    .Cout     (Cout),
    .Ovf      (Ovf)
  );

  // Reference: plain integer arithmetic, borrow view for subtraction.
  function automatic exp_t model(input logic [15:0] a, input logic [15:0] b,
                                 input logic cin, input logic sub);
    exp_t        e;
    logic [16:0] full;
    e = '{default: '0};
    if (sub) begin
      e.sum  = a - b;
      e.cout = (a >= b);
      e.ovf  = (a[15] != b[15]) && (e.sum[15] != a[15]);
    end else begin
      full   = {1'b0, a} + {1'b0, b} + {16'd0, cin};
      e.sum  = full[15:0];
      e.cout = full[16];
      e.ovf  = (a[15] == b[15]) && (e.sum[15] != a[15]);
    end
    return e;
  endfunction

  // One clock: note a result handed over and a beat accepted this cycle.
  task automatic cycle(output bit popped, output bit underflow, output exp_t e,
                       output logic [15:0] s, output logic co, output logic ov);
    #1;
    popped    = out_valid && out_ready;
    underflow = 1'b0;
    e         = '{default: '0};
    s = '0; co = 1'b0; ov = 1'b0;
    if (popped) begin
      s = Sum; co = Cout; ov = Ovf;
      if (q.size() == 0) underflow = 1'b1;
      else e = q.pop_front();
    end
    if (in_valid && in_ready && !rst) begin
      exp_next.acc = cyc;
      q.push_back(exp_next);
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    A = '0; B = '0; Cin = 1'b0; Sub = MODE_ADD;
    repeat (2) @(posedge clk);
    #1;
    n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got=%b want=0", out_valid); end
    n_cmp++; if (Sum !== 16'h0) begin n_fail++; $display("FAIL reset_sum got=%h want=0000", Sum); end
    n_cmp++; if (Cout !== 1'b0) begin n_fail++; $display("FAIL reset_cout got=%b want=0", Cout); end
    n_cmp++; if (Ovf !== 1'b0) begin n_fail++; $display("FAIL reset_ovf got=%b want=0", Ovf); end
    rst = 1'b0;
    @(posedge clk); #1; cyc++;
    n_cmp++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready got=%b want=1", in_ready); end
  endtask

  task automatic test_directed();
    logic [15:0] va[5], vb[5], vs[5];
    logic        vc[5], vm[5], vco[5], vov[5];
    bit p, u, got;
    exp_t e;
    logic [15:0] s;
    logic co, ov;
    int c0;
    va = '{16'h1234, 16'hFFFF, 16'h7FFF, 16'h0005, 16'h8000};
    vb = '{16'h4321, 16'h0001, 16'h0001, 16'h0007, 16'h0001};
    vc = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    vm = '{MODE_ADD, MODE_ADD, MODE_ADD, MODE_SUB, MODE_SUB};
    vs = '{16'h5556, 16'h0000, 16'h8000, 16'hFFFE, 16'h7FFF};
    vco = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    vov = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      A = va[i]; B = vb[i]; Cin = vc[i]; Sub = vm[i]; in_valid = 1'b1;
      exp_next = '{vs[i], vco[i], vov[i], 0};
      cycle(p, u, e, s, co, ov);
      in_valid = 1'b0;
      got = 1'b0;
      for (int t = 0; t < NSEG + 4 && !got; t++) begin
        c0 = cyc;
        cycle(p, u, e, s, co, ov);
        if (p) begin
          got = 1'b1;
          n_cmp++;
          if ({s, co, ov} !== {e.sum, e.cout, e.ovf}) begin
            n_fail++;
            $display("FAIL directed_%0d got sum=%h cout=%b ovf=%b want sum=%h cout=%b ovf=%b",
                     i, s, co, ov, e.sum, e.cout, e.ovf);
          end
          n_cmp++;
          if (u || (c0 - e.acc) != NSEG) begin
            n_fail++;
            $display("FAIL directed_latency_%0d got=%0d want=%0d", i, c0 - e.acc, NSEG);
          end
        end
      end
      n_cmp++;
      if (!got) begin n_fail++; $display("FAIL directed_timeout_%0d got=no result want=result", i); end
    end
  endtask

  task automatic test_back_to_back();
    bit p, u;
    exp_t e;
    logic [15:0] s;
    logic co, ov;
    int npop, first_c, last_c, c0;
    npop = 0; first_c = 0; last_c = 0;
    out_ready = 1'b1;
    for (int i = 0; i < 8 + NSEG + 4; i++) begin
      if (i < 8) begin
        A = 16'($urandom); B = 16'($urandom);
        Cin = 1'($urandom_range(0, 1)); Sub = 1'($urandom_range(0, 1));
        in_valid = 1'b1;
        exp_next = model(A, B, Cin, Sub);
      end else begin
        in_valid = 1'b0;
      end
      c0 = cyc;
      cycle(p, u, e, s, co, ov);
      if (p) begin
        if (npop == 0) first_c = c0;
        last_c = c0;
        npop++;
        n_cmp++;
        if (u || {s, co, ov} !== {e.sum, e.cout, e.ovf}) begin
          n_fail++;
          $display("FAIL b2b_beat_%0d got sum=%h cout=%b ovf=%b want sum=%h cout=%b ovf=%b",
                   npop, s, co, ov, e.sum, e.cout, e.ovf);
        end
      end
    end
    n_cmp++;
    if (npop != 8) begin n_fail++; $display("FAIL b2b_count got=%0d want=8", npop); end
    n_cmp++;
    if (last_c - first_c != 7) begin
      n_fail++; $display("FAIL b2b_consecutive got span=%0d want=7", last_c - first_c);
    end
  endtask

  task automatic test_stall();
    bit p, u, snap_ok;
    exp_t e;
    logic [15:0] s, snap_s;
    logic co, ov, snap_co, snap_ov;
    int npop, nacc;
    snap_ok = 1'b0; npop = 0; nacc = 0;
    snap_s = '0; snap_co = 1'b0; snap_ov = 1'b0;
    out_ready = 1'b0;
    for (int i = 0; i < NSEG + 6; i++) begin
      A = 16'($urandom); B = 16'($urandom);
      Cin = 1'($urandom_range(0, 1)); Sub = 1'($urandom_range(0, 1));
      in_valid = 1'b1;
      exp_next = model(A, B, Cin, Sub);
      #1;
      if (in_ready) nacc++;
      if (out_valid) begin
        n_cmp++;
        if (in_ready !== 1'b0) begin n_fail++; $display("FAIL stall_in_ready_%0d got=%b want=0", i, in_ready); end
        if (snap_ok) begin
          n_cmp++;
          if ({Sum, Cout, Ovf} !== {snap_s, snap_co, snap_ov}) begin
            n_fail++;
            $display("FAIL stall_hold_%0d got sum=%h cout=%b ovf=%b want sum=%h cout=%b ovf=%b",
                     i, Sum, Cout, Ovf, snap_s, snap_co, snap_ov);
          end
        end else begin
          snap_ok = 1'b1; snap_s = Sum; snap_co = Cout; snap_ov = Ovf;
        end
      end
      cycle(p, u, e, s, co, ov);
    end
    in_valid = 1'b0;
    n_cmp++;
    if (nacc != NSEG) begin n_fail++; $display("FAIL stall_accepted got=%0d want=%0d", nacc, NSEG); end
    out_ready = 1'b1;
    for (int t = 0; t < NSEG + 6; t++) begin
      cycle(p, u, e, s, co, ov);
      if (p) begin
        npop++;
        n_cmp++;
        if (u || {s, co, ov} !== {e.sum, e.cout, e.ovf}) begin
          n_fail++;
          $display("FAIL stall_drain_%0d got sum=%h cout=%b ovf=%b want sum=%h cout=%b ovf=%b",
                   npop, s, co, ov, e.sum, e.cout, e.ovf);
        end
      end
    end
    n_cmp++;
    if (npop != NSEG || q.size() != 0) begin
      n_fail++; $display("FAIL stall_drain_count got=%0d left=%0d want=%0d left=0", npop, q.size(), NSEG);
    end
  endtask

  task automatic test_reset_flight();
    bit p, u;
    exp_t e;
    logic [15:0] s;
    logic co, ov;
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      A = 16'h1111 * 16'(i + 1); B = 16'h0102; Cin = 1'b1; Sub = MODE_ADD;
      in_valid = 1'b1;
      exp_next = model(A, B, Cin, Sub);
      cycle(p, u, e, s, co, ov);
    end
    in_valid = 1'b0;
    cycle(p, u, e, s, co, ov);
    n_cmp++;
    if (out_valid !== 1'b1) begin n_fail++; $display("FAIL flight_first_at_output got=%b want=1", out_valid); end
    rst = 1'b1;
    @(posedge clk); #1; cyc++;
    rst = 1'b0;
    q.delete();
    n_cmp++;
    if (out_valid !== 1'b0) begin n_fail++; $display("FAIL flight_reset_valid got=%b want=0", out_valid); end
    n_cmp++;
    if (Sum !== 16'h0) begin n_fail++; $display("FAIL flight_reset_sum got=%h want=0000", Sum); end
    for (int t = 0; t < NSEG + 2; t++) begin
      cycle(p, u, e, s, co, ov);
      n_cmp++;
      if (p) begin n_fail++; $display("FAIL flight_stale_%0d got sum=%h want=no result", t, s); end
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_back_to_back();
    test_stall();
    test_reset_flight();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=time limit want=finish");
    $fatal(1, "watchdog");
  end

endmodule
